// File: rtl/alu_pkg.sv
// Shared opcode constants, flag bit positions and sequencer state encoding
// for the 16-bit ALU execution path.
package alu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_CMP = 4'b0101;
    localparam logic [OP_W-1:0] OP_MOV = 4'b0110;
    localparam logic [OP_W-1:0] OP_RSV = 4'b0111;
    localparam logic [OP_W-1:0] OP_SLL = 4'b1000;
    localparam logic [OP_W-1:0] OP_SLR = 4'b1001;
    localparam logic [OP_W-1:0] OP_SRL = 4'b1010;
    localparam logic [OP_W-1:0] OP_SRA = 4'b1011;

    localparam int unsigned FLAG_S = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_t;

    typedef struct packed {
        logic writes_rd;
        logic updates_flags;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/alu_op_class.sv
// Combinational opcode classifier: does the instruction write rd, update
// the flag register, or fall in the illegal opcode range.
import alu_pkg::*;

module alu_op_class (
    input  logic [3:0] i_op,
    output logic       o_writes_rd,
    output logic       o_updates_flags,
    output logic       o_illegal
);

    always_comb begin
        o_writes_rd     = 1'b0;
        o_updates_flags = 1'b0;
        o_illegal       = 1'b0;
        case (i_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
                o_writes_rd     = 1'b1;
                o_updates_flags = 1'b1;
            end
            OP_CMP: o_updates_flags = 1'b1;
            OP_MOV: o_writes_rd     = 1'b1;
            OP_RSV: ;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Four-cycle IDLE/READ/EXEC/WB sequencer driving the external ALU and register file.
// Build option: ALU_EXEC_CTRL_ILLEGAL_TRAP_EN makes illegal opcodes set a sticky err.
import alu_pkg::*;

module alu_exec_ctrl #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [3:0]    issue_op,
    input  logic [3:0]    issue_d,
    input  logic [AW-1:0] issue_ra,
    input  logic [AW-1:0] issue_rb,
    input  logic [AW-1:0] issue_rd,
    output logic [AW-1:0] rf_raddr_a,
    output logic [AW-1:0] rf_raddr_b,
    input  logic [DW-1:0] rf_rdata_a,
    input  logic [DW-1:0] rf_rdata_b,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [3:0]    alu_opcode,
    output logic [3:0]    alu_d,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_s,
    input  logic          alu_z,
    input  logic          alu_c,
    input  logic          alu_v,
    output logic [3:0]    flags,
    output logic          done,
    output logic          err
);

    state_t              r_state, w_state_nx;
    logic                r_ready, w_ready_nx;
    logic [3:0]          r_op, w_op_nx;
    logic [3:0]          r_d, w_d_nx;
    logic [AW-1:0]       r_rd, w_rd_nx;
    logic [AW-1:0]       r_raddr_a, w_raddr_a_nx;
    logic [AW-1:0]       r_raddr_b, w_raddr_b_nx;
    logic [3:0]          r_alu_op, w_alu_op_nx;
    logic [3:0]          r_alu_d, w_alu_d_nx;
    logic [DW-1:0]       r_alu_a, w_alu_a_nx;
    logic [DW-1:0]       r_alu_b, w_alu_b_nx;
    logic [FLAG_W-1:0]   r_res_flags, w_res_flags_nx;
    logic [FLAG_W-1:0]   r_flags, w_flags_nx;
    logic                r_we, w_we_nx;
    logic [AW-1:0]       r_waddr, w_waddr_nx;
    logic [DW-1:0]       r_wdata, w_wdata_nx;
    logic                r_done, w_done_nx;
    logic                r_err, w_err_nx;
    logic [FLAG_W-1:0]   w_alu_flags;
    op_class_t           w_cls;

    alu_op_class u_op_class (
        .i_op            (r_op),
        .o_writes_rd     (w_cls.writes_rd),
        .o_updates_flags (w_cls.updates_flags),
        .o_illegal       (w_cls.illegal)
    );

    always_comb begin
        w_alu_flags         = '0;
        w_alu_flags[FLAG_S] = alu_s;
        w_alu_flags[FLAG_Z] = alu_z;
        w_alu_flags[FLAG_C] = alu_c;
        w_alu_flags[FLAG_V] = alu_v;
    end

    // Next-state and next-output logic; ALU controls idle on OP_RSV outside EXEC.
    always_comb begin
        w_state_nx     = r_state;
        w_ready_nx     = r_ready;
        w_op_nx        = r_op;
        w_d_nx         = r_d;
        w_rd_nx        = r_rd;
        w_raddr_a_nx   = r_raddr_a;
        w_raddr_b_nx   = r_raddr_b;
        w_alu_op_nx    = OP_RSV;
        w_alu_d_nx     = '0;
        w_alu_a_nx     = '0;
        w_alu_b_nx     = '0;
        w_res_flags_nx = r_res_flags;
        w_flags_nx     = r_flags;
        w_we_nx        = 1'b0;
        w_waddr_nx     = '0;
        w_wdata_nx     = '0;
        w_done_nx      = 1'b0;
        w_err_nx       = r_err;

        case (r_state)
            ST_IDLE: begin
                w_ready_nx = 1'b1;
                if (issue_valid && r_ready) begin
                    w_op_nx      = issue_op;
                    w_d_nx       = issue_d;
                    w_rd_nx      = issue_rd;
                    w_raddr_a_nx = issue_ra;
                    w_raddr_b_nx = issue_rb;
                    w_ready_nx   = 1'b0;
                    w_state_nx   = ST_READ;
                end
            end
            ST_READ: begin
                w_alu_op_nx = r_op;
                w_alu_d_nx  = r_d;
                w_alu_a_nx  = rf_rdata_a;
                w_alu_b_nx  = rf_rdata_b;
                w_state_nx  = ST_EXEC;
            end
            ST_EXEC: begin
                w_res_flags_nx = w_alu_flags;
                w_we_nx        = w_cls.writes_rd && !w_cls.illegal;
                w_waddr_nx     = r_rd;
                w_wdata_nx     = alu_out;
                w_done_nx      = 1'b1;
                w_state_nx     = ST_WB;
            end
            ST_WB: begin
                if (w_cls.updates_flags && !w_cls.illegal) begin
                    w_flags_nx = r_res_flags;
                end
`ifdef ALU_EXEC_CTRL_ILLEGAL_TRAP_EN
                if (w_cls.illegal) begin
                    w_err_nx = 1'b1;
                end
`endif
                w_ready_nx = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_ready_nx = 1'b1;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_op        <= OP_RSV;
            r_d         <= '0;
            r_rd        <= '0;
            r_raddr_a   <= '0;
            r_raddr_b   <= '0;
            r_alu_op    <= OP_RSV;
            r_alu_d     <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_res_flags <= '0;
            r_flags     <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ready     <= w_ready_nx;
            r_op        <= w_op_nx;
            r_d         <= w_d_nx;
            r_rd        <= w_rd_nx;
            r_raddr_a   <= w_raddr_a_nx;
            r_raddr_b   <= w_raddr_b_nx;
            r_alu_op    <= w_alu_op_nx;
            r_alu_d     <= w_alu_d_nx;
            r_alu_a     <= w_alu_a_nx;
            r_alu_b     <= w_alu_b_nx;
            r_res_flags <= w_res_flags_nx;
            r_flags     <= w_flags_nx;
            r_we        <= w_we_nx;
            r_waddr     <= w_waddr_nx;
            r_wdata     <= w_wdata_nx;
            r_done      <= w_done_nx;
            r_err       <= w_err_nx;
        end
    end

    assign issue_ready = r_ready;
    assign rf_raddr_a  = r_raddr_a;
    assign rf_raddr_b  = r_raddr_b;
    assign rf_we       = r_we;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;
    assign alu_opcode  = r_alu_op;
    assign alu_d       = r_alu_d;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign flags       = r_flags;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multi-cycle execution sequencer for the 16-bit ALU. It accepts one decoded instruction at a time over a valid/ready handshake and reads both source operands from the external register file. It drives the combinational ALU, registers the result and the S/Z/C/V outputs, then performs the register write-back and flag-register update. It sits between the decoder and the register file/ALU pair and is the only agent that drives ALU inputs.

## Interface
Parameters:
- `DW`, 16: data width. Must match the ALU.
- `AW`, 3: register-file address width (8 registers).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `issue_valid`  in  1  decoder presents an instruction.
- `issue_ready`  out  1  sequencer can accept an instruction.
- `issue_op`  in  4  ALU opcode.
- `issue_d`  in  4  shift/rotate amount.
- `issue_ra`, `issue_rb`, `issue_rd`  in  AW each  source A, source B, destination.
- `rf_raddr_a`, `rf_raddr_b`  out  AW each  register-file read addresses.
- `rf_rdata_a`, `rf_rdata_b`  in  DW each  read data, one-cycle synchronous latency.
- `rf_we`  out  1  write enable.
- `rf_waddr`  out  AW  write address.
- `rf_wdata`  out  DW  write data.
- `alu_opcode`, `alu_d`  out  4 each  ALU controls.
- `alu_a`, `alu_b`  out  DW each  ALU operands.
- `alu_out`  in  DW  ALU result.
- `alu_s`, `alu_z`, `alu_c`, `alu_v`  in  1 each  ALU flags.
- `flags`  out  4  architectural flags {S,Z,C,V}.
- `done`  out  1  one-cycle pulse at write-back.
- `err`  out  1  sticky illegal-opcode flag (macro-dependent).

## Operation
- FSM states are IDLE, READ, EXEC and WB.
- IDLE:
  - `issue_ready`=1.
  - On `issue_valid`&&`issue_ready`: latch op, d, ra, rb and rd; drive `rf_raddr_a/b` from the latched ra/rb; go to READ.
- READ:
  - Register-file data becomes valid.
  - Latch it into operand registers.
  - Go to EXEC.
- EXEC:
  - `alu_opcode`/`alu_d`/`alu_a`/`alu_b` come from the latched registers.
  - Capture `alu_out` and all four flags into result registers.
  - Go to WB.
- WB:
  - `done`=1.
  - Write-back rules:
    - Opcodes 0000–0100, 0110 and 1000–1011: `rf_we`=1 with rd/result.
    - 0101 (CMP): no write.
    - 0111 (reserved): no write.
  - Flag update rules:
    - Opcodes 0000–0101 and 1000–1011: `flags` loads the captured {S,Z,C,V}.
    - 0110 (MOV): flags unchanged.
    - 0111: flags unchanged.
  - Go to IDLE.
- Opcodes 1100–1111 are illegal; see Configuration.
- Outside EXEC, `alu_opcode`=4'b0111 and operands=0, so the ALU idles on a known value.
- Outside WB, `rf_we`=0.
- rd equal to ra or rb is legal. The write occurs after both reads, so there is no hazard inside the block.

## Timing
- Accept edge is cycle 0; READ is cycle 1, EXEC is cycle 2, WB is cycle 3.
- `done`/`rf_we` are high during cycle 3. `flags` reflect the new value from cycle 4.
- Throughput: one instruction per 4 cycles. `issue_ready` is low during READ, EXEC and WB.
- No back-pressure on write-back; the register file always accepts.
- Reset values: state=IDLE, `issue_ready`=1, `flags`=4'b0000, `done`=0, `rf_we`=0, `err`=0, `alu_opcode`=4'b0111, all address, data and operand outputs 0.
- Reset asserted mid-instruction: the instruction is aborted with no write and no flag change; `issue_ready`=1 on the first edge after deassertion.
- `issue_valid` held high after acceptance: the next instruction is accepted only in IDLE. Holding it is not a duplicate issue, because the decoder advances on the handshake.

## Configuration
- `ALU_EXEC_CTRL_ILLEGAL_TRAP_EN`
  - Defined: an illegal opcode suppresses `rf_we` and the flag update. `done` still pulses, and `err` sets in WB and stays set until reset.
  - Undefined: an illegal opcode executes as a NOP. `done` pulses, with no write and no flag change. `err` is tied to 0.

## Structure
- Shared package `alu_pkg` holds:
  - Opcode constants: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_MOV, OP_RSV, OP_SLL, OP_SLR, OP_SRL, OP_SRA.
  - The FSM state enum.
  - Flag bit indices FLAG_S=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, `alu_op_class`: a combinational decode of the opcode into `writes_rd`, `updates_flags` and `illegal`.
- The ALU itself is instantiated outside this block.

## Test plan
- Reset, then ADD with r1=0x7FFF, r2=0x0001, rd=r3 → `done` in cycle 3; r3=0x8000; flags from the ALU; `issue_ready` back high in cycle 4.
- CMP with r1=0x0005, r2=0x0005 → `rf_we` never asserted; flags Z=1; register file unchanged.
- MOV r4←r2 (0x1234) after a SUB that set Z → r4=0x1234; flags still equal to the post-SUB value.
- SLL with d=4, r1=0x00F1, rd=r1 (rd=ra) → r1=0x0F10; `alu_d`=4 seen during EXEC only.
- Opcode 1110 → with the macro: no write, `err`=1 from cycle 4 and stays set. Without the macro: no write, `err`=0.
- Reset asserted in EXEC of an ADD → no `rf_we` pulse, flags=0000, `issue_ready`=1 after release; a new ADD then completes normally.
